// File: rtl/tmr_lane_monitor.sv
// tmr_lane_monitor
// Receive-side checker for a triplicated datapath. It registers the bitwise
// majority of the three lanes and flags the lanes that disagree with it. A
// per-lane OK/SUSPECT/FAULTY state machine separates transient upsets from
// permanent faults. It latches the faults and pulses fault_irq for one cycle
// when any lane becomes FAULTY.
//
// Ports:
//   clk, rst_n      rising-edge clock, synchronous active-low reset
//   valid_in        data_1/2/3 are sampled this cycle
//   data_1..data_3  the three redundant lane copies
//   clear_i         clears latched faults, FSMs and counters
//   voted_out       registered majority value (held while not valid)
//   voted_valid     voted_out was updated by a valid sample
//   lane_err        per-sample mismatch against the vote, bit0 = lane 1
//   lane_fault      latched FAULTY flag per lane
//   uncorrectable   all three lanes pairwise different in this sample
//   err_cnt_1..3    saturating total mismatch count per lane
//   fault_irq       one-cycle pulse when any lane enters FAULTY
module tmr_lane_monitor #(
  parameter int WIDTH      = 4,
  parameter int ERR_THRESH = 3,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_1,
  input  logic [WIDTH-1:0] data_2,
  input  logic [WIDTH-1:0] data_3,
  input  logic             clear_i,
  output logic [WIDTH-1:0] voted_out,
  output logic             voted_valid,
  output logic [2:0]       lane_err,
  output logic [2:0]       lane_fault,
  output logic             uncorrectable,
  output logic [CNT_W-1:0] err_cnt_1,
  output logic [CNT_W-1:0] err_cnt_2,
  output logic [CNT_W-1:0] err_cnt_3,
  output logic             fault_irq
);

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAULTY  = 2'd2
  } lane_state_e;

  localparam logic [3:0]       THRESH_C = 4'(ERR_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [WIDTH-1:0] lane_data_s [3];
  logic [WIDTH-1:0] vote_s;
  logic [2:0]       mis_s;
  logic             unc_s;

  lane_state_e      state_r      [3];
  lane_state_e      state_nxt_s  [3];
  logic [3:0]       consec_r     [3];
  logic [3:0]       consec_nxt_s [3];
  logic [CNT_W-1:0] cnt_r        [3];
  logic [CNT_W-1:0] cnt_nxt_s    [3];
  logic [2:0]       entering_s;

  logic [WIDTH-1:0] voted_out_r;
  logic             voted_valid_r;
  logic [2:0]       lane_err_r;
  logic [2:0]       lane_fault_r;
  logic             unc_r;
  logic             fault_irq_r;

  assign lane_data_s[0] = data_1;
  assign lane_data_s[1] = data_2;
  assign lane_data_s[2] = data_3;

  // Bitwise majority vote, per-lane mismatch and the all-different condition.
  always_comb begin
    vote_s   = (data_1 & data_2) | (data_1 & data_3) | (data_2 & data_3);
    mis_s[0] = (data_1 != vote_s);
    mis_s[1] = (data_2 != vote_s);
    mis_s[2] = (data_3 != vote_s);
    unc_s    = (data_1 != data_2) && (data_2 != data_3) && (data_1 != data_3);
  end

  // Per-lane persistence FSM, consecutive counter and saturating error
  // counter. clear_i wins over a sample; idle cycles change nothing.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      state_nxt_s[i]  = state_r[i];
      consec_nxt_s[i] = consec_r[i];
      cnt_nxt_s[i]    = cnt_r[i];
      entering_s[i]   = 1'b0;
      if (clear_i) begin
        state_nxt_s[i]  = ST_OK;
        consec_nxt_s[i] = 4'd0;
        cnt_nxt_s[i]    = '0;
      end else if (valid_in) begin
        if (mis_s[i] && (cnt_r[i] != CNT_MAX)) begin
          cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
        end else begin
          cnt_nxt_s[i] = cnt_r[i];
        end
        case (state_r[i])
          ST_OK: begin
            if (mis_s[i]) begin
              consec_nxt_s[i] = 4'd1;
              // A threshold of one skips SUSPECT entirely.
              state_nxt_s[i]  = (4'd1 >= THRESH_C) ? ST_FAULTY : ST_SUSPECT;
            end else begin
              consec_nxt_s[i] = 4'd0;
            end
          end
          ST_SUSPECT: begin
            if (mis_s[i]) begin
              consec_nxt_s[i] = consec_r[i] + 4'd1;
              if ((consec_r[i] + 4'd1) >= THRESH_C) begin
                state_nxt_s[i] = ST_FAULTY;
              end else begin
                state_nxt_s[i] = ST_SUSPECT;
              end
            end else begin
              state_nxt_s[i]  = ST_OK;
              consec_nxt_s[i] = 4'd0;
            end
          end
          ST_FAULTY: begin
            state_nxt_s[i] = ST_FAULTY;
          end
          default: begin
            state_nxt_s[i]  = ST_OK;
            consec_nxt_s[i] = 4'd0;
          end
        endcase
        entering_s[i] = (state_nxt_s[i] == ST_FAULTY) && (state_r[i] != ST_FAULTY);
      end else begin
        state_nxt_s[i] = state_r[i];
      end
    end
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        state_r[i]  <= ST_OK;
        consec_r[i] <= 4'd0;
        cnt_r[i]    <= '0;
      end
      voted_out_r   <= '0;
      voted_valid_r <= 1'b0;
      lane_err_r    <= 3'b000;
      lane_fault_r  <= 3'b000;
      unc_r         <= 1'b0;
      fault_irq_r   <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        state_r[i]      <= state_nxt_s[i];
        consec_r[i]     <= consec_nxt_s[i];
        cnt_r[i]        <= cnt_nxt_s[i];
        lane_fault_r[i] <= (state_nxt_s[i] == ST_FAULTY);
      end
      // Several lanes entering FAULTY together give one pulse.
      fault_irq_r <= |entering_s;
      if (valid_in) begin
        voted_out_r   <= vote_s;
        voted_valid_r <= 1'b1;
        lane_err_r    <= mis_s;
        unc_r         <= unc_s;
      end else begin
        voted_valid_r <= 1'b0;
        lane_err_r    <= 3'b000;
        unc_r         <= 1'b0;
      end
    end
  end

  assign voted_out     = voted_out_r;
  assign voted_valid   = voted_valid_r;
  assign lane_err      = lane_err_r;
  assign lane_fault    = lane_fault_r;
  assign uncorrectable = unc_r;
  assign err_cnt_1     = cnt_r[0];
  assign err_cnt_2     = cnt_r[1];
  assign err_cnt_3     = cnt_r[2];
  assign fault_irq     = fault_irq_r;

endmodule

// File: tb/tb_tmr_lane_monitor.sv
// Directed bench for tmr_lane_monitor. Three instances share the stimulus:
// dut with default parameters, dut_s with CNT_W=2 for counter saturation,
// and dut_t with ERR_THRESH=1. The observed bundle of dut is
// {voted_valid, voted_out, lane_err, uncorrectable, lane_fault, fault_irq}.
module tb_tmr_lane_monitor;

  logic       clk;
  logic       rst_n;
  logic       valid_in;
  logic [3:0] d1, d2, d3;
  logic       clear_i;

  int checks = 0;
  int errors = 0;

  logic [3:0] m_vo;  logic m_vv; logic [2:0] m_le, m_lf; logic m_unc, m_irq;
  logic [7:0] m_c1, m_c2, m_c3;
  logic [3:0] s_vo;  logic s_vv; logic [2:0] s_le, s_lf; logic s_unc, s_irq;
  logic [1:0] s_c1, s_c2, s_c3;
  logic [3:0] t_vo;  logic t_vv; logic [2:0] t_le, t_lf; logic t_unc, t_irq;
  logic [7:0] t_c1, t_c2, t_c3;

  logic [12:0] obs;
  assign obs = {m_vv, m_vo, m_le, m_unc, m_lf, m_irq};

  tmr_lane_monitor dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_1(d1), .data_2(d2),
    .data_3(d3), .clear_i(clear_i), .voted_out(m_vo), .voted_valid(m_vv),
    .lane_err(m_le), .lane_fault(m_lf), .uncorrectable(m_unc),
    .err_cnt_1(m_c1), .err_cnt_2(m_c2), .err_cnt_3(m_c3), .fault_irq(m_irq));

  tmr_lane_monitor #(.CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_1(d1), .data_2(d2),
    .data_3(d3), .clear_i(clear_i), .voted_out(s_vo), .voted_valid(s_vv),
    .lane_err(s_le), .lane_fault(s_lf), .uncorrectable(s_unc),
    .err_cnt_1(s_c1), .err_cnt_2(s_c2), .err_cnt_3(s_c3), .fault_irq(s_irq));

  tmr_lane_monitor #(.ERR_THRESH(1)) dut_t (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_1(d1), .data_2(d2),
    .data_3(d3), .clear_i(clear_i), .voted_out(t_vo), .voted_valid(t_vv),
    .lane_err(t_le), .lane_fault(t_lf), .uncorrectable(t_unc),
    .err_cnt_1(t_c1), .err_cnt_2(t_c2), .err_cnt_3(t_c3), .fault_irq(t_irq));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic clr);
    valid_in = v; d1 = a; d2 = b; d3 = c; clear_i = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (obs !== 13'h0000) begin errors++; $display("FAIL reset_obs got %b exp %b", obs, 13'h0000); end
    checks++; if ({m_c1, m_c2, m_c3} !== 24'h000000) begin errors++; $display("FAIL reset_cnt got %h exp 000000", {m_c1, m_c2, m_c3}); end
    checks++; if ({t_lf, t_irq, s_c1} !== 6'b000000) begin errors++; $display("FAIL reset_aux got %b exp 000000", {t_lf, t_irq, s_c1}); end
  endtask

  task automatic test_agreement();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 4'b1101, 4'b1101, 4'b1101, 1'b0);
      checks++; if (obs !== {1'b1, 4'b1101, 3'b000, 1'b0, 3'b000, 1'b0}) begin errors++; $display("FAIL agree_obs[%0d] got %b exp %b", k, obs, {1'b1, 4'b1101, 3'b000, 1'b0, 3'b000, 1'b0}); end
      checks++; if ({m_c1, m_c2, m_c3} !== 24'h000000) begin errors++; $display("FAIL agree_cnt[%0d] got %h exp 000000", k, {m_c1, m_c2, m_c3}); end
    end
  endtask

  task automatic test_transient();
    do_reset();
    step(1'b1, 4'b1100, 4'b1100, 4'b1001, 1'b0);
    checks++; if (obs !== {1'b1, 4'b1100, 3'b100, 1'b0, 3'b000, 1'b0}) begin errors++; $display("FAIL trans_obs got %b exp %b", obs, {1'b1, 4'b1100, 3'b100, 1'b0, 3'b000, 1'b0}); end
    checks++; if (m_c3 !== 8'd1) begin errors++; $display("FAIL trans_cnt3 got %0d exp 1", m_c3); end
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 4'b1100, 4'b1100, 4'b1100, 1'b0);
      checks++; if (obs !== {1'b1, 4'b1100, 3'b000, 1'b0, 3'b000, 1'b0}) begin errors++; $display("FAIL trans_recover[%0d] got %b exp %b", k, obs, {1'b1, 4'b1100, 3'b000, 1'b0, 3'b000, 1'b0}); end
    end
    // Lane 3 back in OK: two further mismatches must not reach the threshold.
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 4'b1100, 4'b1100, 4'b1001, 1'b0);
      checks++; if ({m_lf, m_irq} !== 4'b0000) begin errors++; $display("FAIL trans_nofault[%0d] got %b exp 0000", k, {m_lf, m_irq}); end
    end
    checks++; if (m_c3 !== 8'd3) begin errors++; $display("FAIL trans_cnt3_total got %0d exp 3", m_c3); end
  endtask

  task automatic test_persistent();
    do_reset();
    step(1'b1, 4'b1111, 4'b1110, 4'b1111, 1'b0);
    checks++; if (obs !== {1'b1, 4'b1111, 3'b010, 1'b0, 3'b000, 1'b0}) begin errors++; $display("FAIL pers_s1 got %b exp %b", obs, {1'b1, 4'b1111, 3'b010, 1'b0, 3'b000, 1'b0}); end
    checks++; if ({t_lf, t_irq} !== 4'b0101) begin errors++; $display("FAIL pers_thresh1 got %b exp 0101", {t_lf, t_irq}); end
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    checks++; if (obs !== {1'b0, 4'b1111, 3'b000, 1'b0, 3'b000, 1'b0}) begin errors++; $display("FAIL pers_idle1 got %b exp %b", obs, {1'b0, 4'b1111, 3'b000, 1'b0, 3'b000, 1'b0}); end
    checks++; if ({t_lf, t_irq} !== 4'b0100) begin errors++; $display("FAIL pers_thresh1_idle got %b exp 0100", {t_lf, t_irq}); end
    step(1'b1, 4'b1111, 4'b1110, 4'b1111, 1'b0);
    checks++; if (obs !== {1'b1, 4'b1111, 3'b010, 1'b0, 3'b000, 1'b0}) begin errors++; $display("FAIL pers_s2 got %b exp %b", obs, {1'b1, 4'b1111, 3'b010, 1'b0, 3'b000, 1'b0}); end
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    step(1'b1, 4'b1111, 4'b1110, 4'b1111, 1'b0);
    checks++; if (obs !== {1'b1, 4'b1111, 3'b010, 1'b0, 3'b010, 1'b1}) begin errors++; $display("FAIL pers_s3 got %b exp %b", obs, {1'b1, 4'b1111, 3'b010, 1'b0, 3'b010, 1'b1}); end
    checks++; if (m_c2 !== 8'd3) begin errors++; $display("FAIL pers_cnt2 got %0d exp 3", m_c2); end
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    checks++; if (obs !== {1'b0, 4'b1111, 3'b000, 1'b0, 3'b010, 1'b0}) begin errors++; $display("FAIL pers_after got %b exp %b", obs, {1'b0, 4'b1111, 3'b000, 1'b0, 3'b010, 1'b0}); end
    step(1'b1, 4'b1111, 4'b1110, 4'b1111, 1'b0);
    checks++; if ({m_lf, m_irq, m_c2} !== {3'b010, 1'b0, 8'd4}) begin errors++; $display("FAIL pers_sticky got %b exp %b", {m_lf, m_irq, m_c2}, {3'b010, 1'b0, 8'd4}); end
  endtask

  task automatic test_uncorrectable();
    do_reset();
    step(1'b1, 4'b1000, 4'b1110, 4'b1011, 1'b0);
    checks++; if (obs !== {1'b1, 4'b1010, 3'b111, 1'b1, 3'b000, 1'b0}) begin errors++; $display("FAIL unc_obs got %b exp %b", obs, {1'b1, 4'b1010, 3'b111, 1'b1, 3'b000, 1'b0}); end
    checks++; if ({m_c1, m_c2, m_c3} !== {8'd1, 8'd1, 8'd1}) begin errors++; $display("FAIL unc_cnt got %h exp 010101", {m_c1, m_c2, m_c3}); end
    step(1'b1, 4'b1000, 4'b1110, 4'b1011, 1'b0);
    step(1'b1, 4'b1000, 4'b1110, 4'b1011, 1'b0);
    checks++; if (obs !== {1'b1, 4'b1010, 3'b111, 1'b1, 3'b111, 1'b1}) begin errors++; $display("FAIL unc_allfault got %b exp %b", obs, {1'b1, 4'b1010, 3'b111, 1'b1, 3'b111, 1'b1}); end
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    checks++; if (obs !== {1'b0, 4'b1010, 3'b000, 1'b0, 3'b111, 1'b0}) begin errors++; $display("FAIL unc_single_irq got %b exp %b", obs, {1'b0, 4'b1010, 3'b000, 1'b0, 3'b111, 1'b0}); end
  endtask

  task automatic test_saturation_clear();
    logic [1:0] exp_s;
    logic [2:0] exp_f;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b0);
      exp_s = (k >= 3) ? 2'd3 : 2'(k);
      exp_f = (k >= 3) ? 3'b001 : 3'b000;
      checks++; if ({m_c1, s_c1} !== {8'(k), exp_s}) begin errors++; $display("FAIL sat_cnt[%0d] got %0d/%0d exp %0d/%0d", k, m_c1, s_c1, k, exp_s); end
      checks++; if (obs !== {1'b1, 4'b0000, 3'b001, 1'b0, exp_f, (k == 3)}) begin errors++; $display("FAIL sat_obs[%0d] got %b exp %b", k, obs, {1'b1, 4'b0000, 3'b001, 1'b0, exp_f, (k == 3)}); end
    end
    step(1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b1);
    checks++; if (obs !== {1'b1, 4'b0000, 3'b001, 1'b0, 3'b000, 1'b0}) begin errors++; $display("FAIL clr_obs got %b exp %b", obs, {1'b1, 4'b0000, 3'b001, 1'b0, 3'b000, 1'b0}); end
    checks++; if ({m_c1, s_c1} !== 10'd0) begin errors++; $display("FAIL clr_cnt got %0d/%0d exp 0/0", m_c1, s_c1); end
    step(1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    checks++; if ({m_c1, m_lf, m_irq} !== {8'd1, 3'b000, 1'b0}) begin errors++; $display("FAIL clr_restart got %b exp %b", {m_c1, m_lf, m_irq}, {8'd1, 3'b000, 1'b0}); end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    for (int k = 1; k <= 2; k++) begin
      step(1'b1, 4'b0000, 4'b0100, 4'b0000, 1'b0);
      checks++; if ({obs, m_c2} !== {1'b1, 4'b0000, 3'b010, 1'b0, 3'b000, 1'b0, 8'(k)}) begin errors++; $display("FAIL mid_pre[%0d] got %b exp %b", k, {obs, m_c2}, {1'b1, 4'b0000, 3'b010, 1'b0, 3'b000, 1'b0, 8'(k)}); end
    end
    rst_n = 1'b0;
    step(1'b1, 4'b0000, 4'b0100, 4'b0000, 1'b0);
    rst_n = 1'b1;
    checks++; if ({obs, m_c2} !== 21'd0) begin errors++; $display("FAIL mid_reset got %b exp 0", {obs, m_c2}); end
    for (int k = 1; k <= 2; k++) begin
      step(1'b1, 4'b0000, 4'b0100, 4'b0000, 1'b0);
      checks++; if ({obs, m_c2} !== {1'b1, 4'b0000, 3'b010, 1'b0, 3'b000, 1'b0, 8'(k)}) begin errors++; $display("FAIL mid_post[%0d] got %b exp %b", k, {obs, m_c2}, {1'b1, 4'b0000, 3'b010, 1'b0, 3'b000, 1'b0, 8'(k)}); end
    end
    step(1'b1, 4'b0000, 4'b0100, 4'b0000, 1'b0);
    checks++; if ({m_lf, m_irq} !== 4'b0101) begin errors++; $display("FAIL mid_third got %b exp 0101", {m_lf, m_irq}); end
  endtask

  initial begin
    rst_n = 1'b1; valid_in = 1'b0; d1 = 4'h0; d2 = 4'h0; d3 = 4'h0; clear_i = 1'b0;
    test_reset();
    test_agreement();
    test_transient();
    test_persistent();
    test_uncorrectable();
    test_saturation_clear();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
